timer_counter: RTL and testbench



---
 rtl/timer_counter.sv | 168 ++++++++++++++++
 tb/tb_timer_counter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer that answers the bus
// bridge's timer window and raises a level interrupt request.
// Registers: CTRL (0), PRESET (1), COUNT (2, read-only), address 3 unmapped.
// Optional feature macro: TIMER_AUTORELOAD_EN enables the auto-reload mode
// (CTRL[2:1] = 01). Without it every count is one-shot and CTRL[2:1] reads 0.
module timer_counter (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [1:0]  ADD_I,
    input  logic        WE_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        enable;
    logic        im;
    logic [1:0]  mode;
    logic [31:0] preset;
    logic [31:0] count;
    logic        flag;

    logic        auto_reload;
    logic        ctrl_write;
    logic        preset_write;
    logic        hw_clear_enable;
    logic        flag_set;
    logic        flag_clear;

    assign ctrl_write   = WE_I && (ADD_I == 2'd0);
    assign preset_write = WE_I && (ADD_I == 2'd1);

`ifdef TIMER_AUTORELOAD_EN
    assign auto_reload = (mode == 2'b01);
`else
    assign mode        = 2'b00;
    assign auto_reload = 1'b0;
`endif

    // A finished one-shot count drops Enable on its way out of INT.
    assign hw_clear_enable = (state == ST_INT) && !auto_reload;

    // The sticky flag is raised on entry to INT and held through the INT
    // cycle, so a clearing bus write that coincides with it never loses it.
    assign flag_set   = !auto_reload &&
                        (((state == ST_CNT) && enable && (count == 32'd0)) ||
                         (state == ST_INT));
    assign flag_clear = ctrl_write || preset_write;

    // State register for the counting sequencer.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE -> LOAD -> CNT -> INT -> (IDLE | LOAD).
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                next_state = ST_CNT;
            end
            ST_CNT: begin
                if (!enable) begin
                    next_state = ST_IDLE;
                end else if (count == 32'd0) begin
                    next_state = ST_INT;
                end
            end
            ST_INT: begin
                next_state = auto_reload ? ST_LOAD : ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // CTRL register; a bus write takes priority over the hardware Enable clear.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            enable <= 1'b0;
            im     <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
            mode   <= 2'b00;
`endif
        end else if (ctrl_write) begin
            enable <= DAT_I[0];
            im     <= DAT_I[3];
`ifdef TIMER_AUTORELOAD_EN
            mode   <= DAT_I[2:1];
`endif
        end else if (hw_clear_enable) begin
            enable <= 1'b0;
        end
    end

    // PRESET register; only consulted in LOAD, so mid-count writes wait.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            preset <= 32'd0;
        end else if (preset_write) begin
            preset <= DAT_I;
        end
    end

    // COUNT loads from PRESET in LOAD and decrements in CNT; it freezes when paused.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            count <= 32'd0;
        end else if (state == ST_LOAD) begin
            count <= preset;
        end else if ((state == ST_CNT) && enable && (count != 32'd0)) begin
            count <= count - 32'd1;
        end
    end

    // Sticky one-shot interrupt flag; set beats clear.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            flag <= 1'b0;
        end else if (flag_set) begin
            flag <= 1'b1;
        end else if (flag_clear) begin
            flag <= 1'b0;
        end
    end

    // Interrupt request derived only from registered state.
    always_comb begin
        IRQ = 1'b0;
        if (auto_reload) begin
            IRQ = (state == ST_INT) && im;
        end else begin
            IRQ = flag && im;
        end
    end

    // Read mux, combinational from the word select.
    always_comb begin
        DAT_O = 32'd0;
        case (ADD_I)
            2'd0:    DAT_O = {28'd0, im, mode, enable};
            2'd1:    DAT_O = preset;
            2'd2:    DAT_O = count;
            default: DAT_O = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: self-checking bench for timer_counter. Expected COUNT,
// CTRL and IRQ values come from a timeline model indexed by cycles since
// Enable was written. Works with or without TIMER_AUTORELOAD_EN.
module tb_timer_counter;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b0;
    logic [1:0]  ADD_I = 2'd0;
    logic        WE_I  = 1'b0;
    logic [31:0] DAT_I = 32'd0;
    logic [31:0] DAT_O;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

`ifdef TIMER_AUTORELOAD_EN
    localparam bit RELOAD_BUILT = 1'b1;
`else
    localparam bit RELOAD_BUILT = 1'b0;
`endif

    timer_counter dut (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .ADD_I (ADD_I),
        .WE_I  (WE_I),
        .DAT_I (DAT_I),
        .DAT_O (DAT_O),
        .IRQ   (IRQ)
    );

    // Free-running clock, 20 time-unit period.
    always #10 CLK_I = ~CLK_I;

    // Safety net so the run can never hang.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_reset();
        @(negedge CLK_I);
        WE_I  = 1'b0;
        RST_I = 1'b1;
        @(negedge CLK_I);
        RST_I = 1'b0;
    endtask

    // One full-word bus write; the write lands on the next rising edge.
    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge CLK_I);
        ADD_I = addr;
        DAT_I = data;
        WE_I  = 1'b1;
        @(posedge CLK_I);
        #1;
        WE_I  = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] addr, output logic [31:0] data);
        ADD_I = addr;
        #1;
        data = DAT_O;
    endtask

    function automatic logic [31:0] ctrl_image(input logic [3:0] v, input logic en);
        return {28'd0, v[3], (RELOAD_BUILT ? v[2:1] : 2'b00), en};
    endfunction

    // Timeline model: k edges after Enable was written (counter starting from
    // reset), with preset p. One-shot: two set-up cycles, then P..0, then a
    // held interrupt. Auto-reload: period p+3 starting with a load cycle.
    function automatic void model_at(input int k, input int p, input bit reload,
                                     input bit im, output logic [31:0] cnt,
                                     output logic irq, output logic en);
        int ph;
        cnt = 32'd0;
        irq = 1'b0;
        en  = 1'b1;
        if (reload) begin
            ph = (k - 1) % (p + 3);
            if (k >= 1 && ph >= 1 && ph <= p + 1) cnt = p - (ph - 1);
            irq = (k >= 1) && (ph == p + 2) && im;
        end else begin
            if (k >= 2 && (k - 2) <= p) begin
                cnt = p - (k - 2);
            end else if (k > p + 2) begin
                irq = im;
                en  = (k <= p + 3);
            end
        end
    endfunction

    task automatic run_scenario(input string name, input int p,
                                input logic [3:0] ctrl_val, input int cycles);
        logic [31:0] d;
        logic [31:0] exp_cnt;
        logic        exp_irq;
        logic        exp_en;
        bit          reload;
        reload = RELOAD_BUILT && (ctrl_val[2:1] == 2'b01);
        apply_reset();
        bus_write(2'd1, p);
        read_reg(2'd1, d);
        check_output({name, " preset"}, d, p);
        bus_write(2'd0, {28'd0, ctrl_val});
        for (int k = 1; k <= cycles; k++) begin
            @(posedge CLK_I);
            #1;
            model_at(k, p, reload, ctrl_val[3], exp_cnt, exp_irq, exp_en);
            read_reg(2'd2, d);
            check_output($sformatf("%s count k=%0d", name, k), d, exp_cnt);
            read_reg(2'd0, d);
            check_output($sformatf("%s ctrl k=%0d", name, k), d, ctrl_image(ctrl_val, exp_en));
            check_output($sformatf("%s irq k=%0d", name, k), {31'd0, IRQ}, {31'd0, exp_irq});
        end
    endtask

    // Directed steps followed by randomized scenarios.
    initial begin
        logic [31:0] d;
        logic [31:0] shadow_ctrl;
        logic [31:0] shadow_preset;
        logic [31:0] wdata;
        logic [1:0]  waddr;

        $display("[TB] start, auto-reload built = %0d", RELOAD_BUILT);

        // Reset values
        RST_I = 1'b1;
        repeat (2) @(posedge CLK_I);
        #2;
        for (int a = 0; a < 4; a++) begin
            read_reg(a[1:0], d);
            check_output($sformatf("reset dat_o addr%0d", a), d, 32'd0);
        end
        check_output("reset irq", {31'd0, IRQ}, 32'd0);
        @(negedge CLK_I);
        RST_I = 1'b0;

        // Register access with Enable held low; COUNT and address 3 ignore writes
        shadow_ctrl   = 32'd0;
        shadow_preset = 32'd0;
        for (int i = 0; i < 12; i++) begin
            waddr = 2'($urandom_range(0, 3));
            wdata = $urandom;
            if (waddr == 2'd0) wdata[0] = 1'b0;
            bus_write(waddr, wdata);
            if (waddr == 2'd0) shadow_ctrl = ctrl_image(wdata[3:0], 1'b0);
            if (waddr == 2'd1) shadow_preset = wdata;
            read_reg(2'd0, d);
            check_output("regs ctrl", d, shadow_ctrl);
            read_reg(2'd1, d);
            check_output("regs preset", d, shadow_preset);
            read_reg(2'd2, d);
            check_output("regs count", d, 32'd0);
            read_reg(2'd3, d);
            check_output("regs addr3", d, 32'd0);
            check_output("regs irq", {31'd0, IRQ}, 32'd0);
        end

        // Reset asserted mid-count clears everything at once
        apply_reset();
        bus_write(2'd1, 32'd5);
        bus_write(2'd0, 32'h1);
        repeat (4) @(posedge CLK_I);
        #2;
        RST_I = 1'b1;
        #1;
        for (int a = 0; a < 4; a++) begin
            read_reg(a[1:0], d);
            check_output($sformatf("midreset dat_o addr%0d", a), d, 32'd0);
        end
        check_output("midreset irq", {31'd0, IRQ}, 32'd0);
        @(negedge CLK_I);
        RST_I = 1'b0;

        // One-shot, PRESET 4; then a CTRL write drops the interrupt
        run_scenario("oneshot4", 4, 4'h9, 12);
        bus_write(2'd0, 32'h8);
        check_output("oneshot4 irq cleared", {31'd0, IRQ}, 32'd0);
        read_reg(2'd0, d);
        check_output("oneshot4 ctrl after clear", d, 32'h8);

        // PRESET 0 one-shot
        run_scenario("oneshot0", 0, 4'h9, 6);

        // Auto-reload with IM set and with IM clear
        run_scenario("reload_im", 2, 4'hB, 17);
        run_scenario("reload_noim", 2, 4'h3, 17);

        // All CTRL bits written; mode bits only survive with auto-reload built
        run_scenario("ctrl_f", 1, 4'hF, 14);

        // Pause at COUNT 6 then resume from PRESET
        apply_reset();
        bus_write(2'd1, 32'd10);
        bus_write(2'd0, 32'h1);
        repeat (5) @(posedge CLK_I);
        #1;
        read_reg(2'd2, d);
        check_output("pause before", d, 32'd7);
        bus_write(2'd0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK_I);
            #1;
            read_reg(2'd2, d);
            check_output($sformatf("pause hold %0d", i), d, 32'd6);
        end
        bus_write(2'd0, 32'h1);
        @(posedge CLK_I);
        #1;
        read_reg(2'd2, d);
        check_output("resume load cycle", d, 32'd6);
        @(posedge CLK_I);
        #1;
        read_reg(2'd2, d);
        check_output("resume reloaded", d, 32'd10);
        @(posedge CLK_I);
        #1;
        read_reg(2'd2, d);
        check_output("resume counting", d, 32'd9);

        // CTRL write during the INT cycle is kept and the flag survives
        apply_reset();
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h9);
        repeat (4) @(posedge CLK_I);
        #1;
        check_output("intwrite before int", {31'd0, IRQ}, 32'd0);
        @(posedge CLK_I);
        #1;
        check_output("intwrite in int", {31'd0, IRQ}, 32'd1);
        bus_write(2'd0, 32'h9);
        read_reg(2'd0, d);
        check_output("intwrite ctrl kept", d, 32'h9);
        check_output("intwrite flag kept", {31'd0, IRQ}, 32'd1);
        bus_write(2'd0, 32'h8);
        check_output("intwrite later clear", {31'd0, IRQ}, 32'd0);

        // Randomized scenarios
        for (int i = 0; i < 8; i++) begin
            int p;
            logic [3:0] cv;
            p  = $urandom_range(0, 6);
            cv = {3'($urandom_range(0, 7)), 1'b1};
            run_scenario($sformatf("rand%0d", i), p, cv, 3 * (p + 3) + 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
